a2d_sequencer: RTL and testbench



---
 rtl/a2d_pkg.sv | 31 +++
 rtl/a2d_dead_timer.sv | 33 +++
 rtl/a2d_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_a2d_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | a2d_pkg                                                                  |
// | Shared types, slot indices and command-word builder for a2d_sequencer.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package a2d_pkg;

  localparam int NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DEAD = 2'd2,
    READ = 2'd3
  } state_t;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_LFT   = 2'd0;
  localparam slot_t SLOT_RGHT  = 2'd1;
  localparam slot_t SLOT_STEER = 2'd2;
  localparam slot_t SLOT_BATT  = 2'd3;

  // The converter only looks at the channel field; everything else is zero.
  function automatic logic [15:0] build_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/a2d_dead_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | a2d_dead_timer                                                           |
// | Loadable down-counter spacing the two SPI transactions of a conversion.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module a2d_dead_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/a2d_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | a2d_sequencer                                                            |
// | Round-robin A2D conversion sequencer driving the shared SPI master.      |
// | Optional battery-low flag enabled by defining BATT_LOW_EN.               |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module a2d_sequencer
  import a2d_pkg::*;
#(
  parameter logic [2:0]  LFT_CH      = 3'd0,
  parameter logic [2:0]  RGHT_CH     = 3'd4,
  parameter logic [2:0]  STEER_CH    = 3'd5,
  parameter logic [2:0]  BATT_CH     = 3'd6,
  parameter int          DEAD_CYC    = 2,
  parameter logic [11:0] BATT_THRESH = 12'h800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_vld,
  output logic        busy,
  output logic        batt_low
);

  // DEAD lasts DEAD_CYC clocks; the zero-count cycle is the last of them.
  localparam logic [3:0] c_dead_load = 4'(DEAD_CYC - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  slot_t       r_ptr;
  logic        r_spi_wrt;
  logic        r_cnv_vld;
  logic        r_busy;
  logic [15:0] r_spi_cmd;
  logic [11:0] r_res [NUM_SLOTS];

  logic        w_wrt_nxt;
  logic        w_vld_nxt;
  logic        w_busy_nxt;
  logic        w_cmd_ld;
  logic        w_capture;
  logic        w_tmr_load;
  logic        w_tmr_en;
  logic        w_tmr_zero;
  logic [2:0]  w_ch;
  logic        w_unused_hi;

  assign w_unused_hi = ^spi_rd_data[15:12];

  always_comb begin
    w_ch = LFT_CH;
    case (r_ptr)
      SLOT_LFT:   w_ch = LFT_CH;
      SLOT_RGHT:  w_ch = RGHT_CH;
      SLOT_STEER: w_ch = STEER_CH;
      SLOT_BATT:  w_ch = BATT_CH;
      default:    w_ch = LFT_CH;
    endcase
  end

  a2d_dead_timer #(
    .WIDTH    (4)
  ) u_dead_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_tmr_load),
    .en       (w_tmr_en),
    .load_val (c_dead_load),
    .zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wrt_nxt   = 1'b0;
    w_vld_nxt   = 1'b0;
    w_busy_nxt  = r_busy;
    w_cmd_ld    = 1'b0;
    w_capture   = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_en    = 1'b0;
    case (r_state)
      IDLE: begin
        // A request coinciding with the completion pulse is dropped.
        if (nxt && !r_cnv_vld) begin
          w_wrt_nxt   = 1'b1;
          w_cmd_ld    = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = CMD;
        end
      end
      CMD: begin
        if (spi_done) begin
          w_tmr_load  = 1'b1;
          w_state_nxt = DEAD;
        end
      end
      DEAD: begin
        if (w_tmr_zero) begin
          w_wrt_nxt   = 1'b1;
          w_state_nxt = READ;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      READ: begin
        if (spi_done) begin
          w_capture   = 1'b1;
          w_vld_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spi_wrt <= 1'b0;
      r_cnv_vld <= 1'b0;
      r_busy    <= 1'b0;
      r_spi_cmd <= 16'h0000;
      r_ptr     <= SLOT_LFT;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_res[i] <= 12'h000;
      end
    end else begin
      r_spi_wrt <= w_wrt_nxt;
      r_cnv_vld <= w_vld_nxt;
      r_busy    <= w_busy_nxt;
      if (w_cmd_ld) begin
        r_spi_cmd <= build_cmd(w_ch);
      end
      if (w_capture) begin
        r_res[r_ptr] <= spi_rd_data[11:0];
        r_ptr        <= r_ptr + 2'd1;
      end
    end
  end

`ifdef BATT_LOW_EN
  logic r_batt_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_batt_low <= 1'b0;
    end else if (w_capture && (r_ptr == SLOT_BATT)) begin
      r_batt_low <= (spi_rd_data[11:0] < BATT_THRESH);
    end
  end

  assign batt_low = r_batt_low;
`else
  logic w_unused_thresh;

  assign w_unused_thresh = ^BATT_THRESH;
  assign batt_low        = 1'b0;
`endif

  assign spi_wrt   = r_spi_wrt;
  assign spi_cmd   = r_spi_cmd;
  assign cnv_vld   = r_cnv_vld;
  assign busy      = r_busy;
  assign lft_ld    = r_res[SLOT_LFT];
  assign rght_ld   = r_res[SLOT_RGHT];
  assign steer_pot = r_res[SLOT_STEER];
  assign batt      = r_res[SLOT_BATT];

endmodule
`default_nettype wire

// File: tb/tb_a2d_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_a2d_sequencer                                                         |
// | Scoreboard bench for a2d_sequencer; honours BATT_LOW_EN when defined.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_a2d_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        nxt = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd_data = 16'h0000;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic        cnv_vld;
  logic        busy;
  logic        batt_low;

  typedef struct {
    logic [1:0]  slot;
    logic [11:0] val;
  } sb_t;

  sb_t         sb[$];
  sb_t         sb_e;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          wrt_cnt = 0;
  int          vld_cnt = 0;
  logic [1:0]  exp_ptr = 2'd0;
  logic [15:0] cmd_tab [4] = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};

  a2d_sequencer u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nxt         (nxt),
    .spi_done    (spi_done),
    .spi_rd_data (spi_rd_data),
    .spi_wrt     (spi_wrt),
    .spi_cmd     (spi_cmd),
    .lft_ld      (lft_ld),
    .rght_ld     (rght_ld),
    .steer_pot   (steer_pot),
    .batt        (batt),
    .cnv_vld     (cnv_vld),
    .busy        (busy),
    .batt_low    (batt_low)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [11:0] res_of(input logic [1:0] slot);
    case (slot)
      2'd0:    return lft_ld;
      2'd1:    return rght_ld;
      2'd2:    return steer_pot;
      default: return batt;
    endcase
  endfunction

  function automatic logic exp_low(input logic [11:0] v);
`ifdef BATT_LOW_EN
    return (v < 12'h800);
`else
    return 1'b0;
`endif
  endfunction

  // Output monitor: counts pulses and retires scoreboard entries on cnv_vld.
  always @(posedge clk) begin
    #1;
    if (spi_wrt === 1'b1) wrt_cnt++;
    if (cnv_vld === 1'b1) begin
      vld_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_vld", 32'd1, 32'd0);
      end else begin
        sb_e = sb.pop_front();
        chk("result", res_of(sb_e.slot), sb_e.val);
      end
    end
  end

  // One conversion with the SPI master modelled inline.
  task automatic conv(input logic [15:0] rd, input bit extra_nxt, input bit abort);
    int w0;
    int v0;
    int dly;
    @(negedge clk);
    nxt = 1'b1;
    sb.push_back('{exp_ptr, rd[11:0]});
    w0 = wrt_cnt;
    v0 = vld_cnt;
    @(negedge clk);
    nxt = 1'b0;
    chk("wrt1", spi_wrt, 1);
    chk("cmd1", spi_cmd, cmd_tab[exp_ptr]);
    chk("busy_set", busy, 1);
    for (int i = 0; i < 3; i++) begin
      nxt = (extra_nxt && i == 0);
      @(negedge clk);
    end
    nxt = 1'b0;
    spi_done = 1'b1;
    spi_rd_data = 16'hBEEF;
    @(negedge clk);
    spi_done = 1'b0;
    dly = 1;
    if (abort) begin
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_wrt", spi_wrt, 0);
      chk("abort_regs", {lft_ld, rght_ld, steer_pot, batt} == 48'h0, 1);
      sb.delete();
      exp_ptr = 2'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    while (spi_wrt !== 1'b1 && dly < 20) begin
      @(negedge clk);
      dly++;
    end
    chk("dead_gap", dly, 3);
    chk("cmd2", spi_cmd, cmd_tab[exp_ptr]);
    for (int i = 0; i < 2; i++) begin
      nxt = (extra_nxt && i == 0);
      @(negedge clk);
    end
    nxt = 1'b0;
    spi_done = 1'b1;
    spi_rd_data = rd;
    @(negedge clk);
    spi_done = 1'b0;
    spi_rd_data = 16'h0000;
    chk("cnv_vld", cnv_vld, 1);
    chk("busy_clr", busy, 0);
    if (extra_nxt) nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    repeat (3) @(negedge clk);
    chk("wrt_per_conv", wrt_cnt - w0, 2);
    chk("vld_per_conv", vld_cnt - v0, 1);
    chk("cmd_hold", spi_cmd, cmd_tab[exp_ptr]);
    exp_ptr = exp_ptr + 2'd1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_lft", lft_ld, 0);
    chk("rst_rght", rght_ld, 0);
    chk("rst_steer", steer_pot, 0);
    chk("rst_batt", batt, 0);
    chk("rst_wrt", spi_wrt, 0);
    chk("rst_cmd", spi_cmd, 0);
    chk("rst_vld", cnv_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_low", batt_low, 0);
    rst_n = 1'b1;

    conv(16'hF123, 0, 0);
    conv(16'h0456, 0, 0);
    conv(16'h0789, 0, 0);
    conv(16'h0ABC, 0, 0);
    chk("round_lft", lft_ld, 12'h123);
    chk("round_rght", rght_ld, 12'h456);
    chk("round_steer", steer_pot, 12'h789);
    chk("round_batt", batt, 12'hABC);
    chk("round_low", batt_low, exp_low(12'hABC));

    conv(16'h0111, 1, 0);
    conv(16'h0222, 0, 0);
    conv(16'h0333, 0, 1);
    chk("post_abort_busy", busy, 0);
    conv(16'h0F00, 0, 0);
    conv(16'h0100, 0, 0);
    conv(16'h0200, 0, 0);
    conv(16'h07FF, 0, 0);
    chk("batt_7ff", batt, 12'h7FF);
    chk("low_7ff", batt_low, exp_low(12'h7FF));
    conv(16'h0001, 0, 0);
    chk("low_hold", batt_low, exp_low(12'h7FF));
    conv(16'h0002, 0, 0);
    conv(16'h0003, 0, 0);
    conv(16'hF800, 0, 0);
    chk("batt_800", batt, 12'h800);
    chk("low_800", batt_low, exp_low(12'h800));
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
